// File: rtl/cp0_intc.sv
// Coprocessor 0 with NUM_INT level/edge interrupt lines, optional Count/Compare timer and exception entry.
// int_req is combinational from registered state; all register updates land at the next clk edge. No backpressure.
module cp0_intc #(
  parameter int                 NUM_INT   = 6,
  parameter int                 IM_LSB    = 10,
  parameter logic [NUM_INT-1:0] EDGE_MASK = '0,
  parameter bit                 HAS_TIMER = 1'b0,
  parameter logic [31:0]        PRID      = 32'h4D49_5053
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] hw_int,
  input  logic [4:0]         addr,
  input  logic [31:0]        din,
  input  logic               we,
  input  logic [31:0]        pc,
  input  logic               bd,
  input  logic [4:0]         exc_code,
  input  logic               exl_clr,
  output logic               int_req,
  output logic [31:0]        epc_out,
  output logic [31:0]        dout
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [NUM_INT-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [4:0]         cause_exc;
  logic [NUM_INT-1:0] ip_q;
  logic [NUM_INT-1:0] prev_q;
  logic [31:0]        epc_q;
  logic [31:0]        count_q;
  logic [31:0]        compare_q;
  logic               timer_flag;

  logic [NUM_INT-1:0] ip_vis;
  logic [NUM_INT-1:0] ip_nxt;
  logic               irq;
  logic               erq;
  logic               wr_ok;
  logic               cause_wr;
  logic [31:0]        pc_word;
  logic [31:0]        sr_rd;
  logic [31:0]        cause_rd;

  always_comb begin
    ip_vis = ip_q;
    if (HAS_TIMER) begin
      ip_vis[NUM_INT-1] = ip_q[NUM_INT-1] | timer_flag;
    end
  end

  assign irq      = (|(ip_vis & sr_im)) & sr_ie & ~sr_exl;
  assign erq      = (exc_code != 5'd0) & ~sr_exl;
  assign int_req  = irq | erq;
  // Exception entry wins over any mtc0 presented in the same cycle.
  assign wr_ok    = we & ~int_req;
  assign cause_wr = wr_ok && (addr == A_CAUSE);
  assign pc_word  = pc & 32'hFFFF_FFFC;
  assign epc_out  = epc_q;

  // Edge lines: a fresh rising edge sets even when a write-0 clears the same cycle.
  always_comb begin
    ip_nxt = hw_int;
    for (int i = 0; i < NUM_INT; i++) begin
      if (EDGE_MASK[i]) begin
        ip_nxt[i] = (hw_int[i] & ~prev_q[i]) |
                    (ip_q[i] & ~(cause_wr & ~din[IM_LSB+i]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
      ip_q      <= '0;
      prev_q    <= '0;
      epc_q     <= 32'd0;
    end else begin
      ip_q   <= ip_nxt;
      prev_q <= hw_int;
      if (int_req) begin
        sr_exl    <= 1'b1;
        cause_exc <= irq ? 5'd0 : exc_code;
        cause_bd  <= bd;
        epc_q     <= bd ? (pc_word - 32'd4) : pc_word;
      end else begin
        if (we && addr == A_SR) begin
          sr_im  <= din[IM_LSB +: NUM_INT];
          sr_exl <= din[1];
          sr_ie  <= din[0];
        end
        if (we && addr == A_EPC) begin
          epc_q <= din & 32'hFFFF_FFFC;
        end
        // eret overrides an EXL value written by mtc0 in the same cycle.
        if (exl_clr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !HAS_TIMER) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      timer_flag <= 1'b0;
    end else begin
      count_q <= (wr_ok && addr == A_COUNT) ? din : count_q + 32'd1;
      if (wr_ok && addr == A_COMPARE) begin
        compare_q  <= din;
        timer_flag <= 1'b0;
      end else if (count_q == compare_q && compare_q != 32'd0) begin
        timer_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    sr_rd                      = 32'd0;
    sr_rd[IM_LSB +: NUM_INT]   = sr_im;
    sr_rd[1]                   = sr_exl;
    sr_rd[0]                   = sr_ie;
    cause_rd                   = 32'd0;
    cause_rd[31]               = cause_bd;
    cause_rd[IM_LSB +: NUM_INT] = ip_vis;
    cause_rd[6:2]              = cause_exc;
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      A_COUNT:   dout = count_q;
      A_COMPARE: dout = compare_q;
      A_SR:      dout = sr_rd;
      A_CAUSE:   dout = cause_rd;
      A_EPC:     dout = epc_q;
      A_PRID:    dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: directed scenarios plus randomized traffic against a register-word reference model.
module tb_cp0_intc;

  localparam logic [5:0]  EDGE = 6'b000010;
  localparam logic [31:0] PRID = 32'h4D49_5053;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  cp0_intc #(
    .NUM_INT(6), .IM_LSB(10), .EDGE_MASK(EDGE), .HAS_TIMER(1'b1), .PRID(PRID)
  ) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .addr(addr), .din(din), .we(we),
    .pc(pc), .bd(bd), .exc_code(exc_code), .exl_clr(exl_clr),
    .int_req(int_req), .epc_out(epc_out), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference model: whole architectural register words.
  logic [31:0] m_sr, m_epc, m_count, m_compare;
  logic [5:0]  m_ip, m_prev;
  logic        m_tflag, m_bd;
  logic [4:0]  m_exc;

  function automatic logic [5:0] m_ipv();
    return m_ip | {m_tflag, 5'b0};
  endfunction

  function automatic logic m_irq();
    return ((m_ipv() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_irq() || (exc_code != 5'd0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_sr;
      5'd13:   return {m_bd, 15'd0, m_ipv(), 3'd0, m_exc, 2'd0};
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic        req, irq, wr, tf;
    logic [5:0]  nip;
    logic [31:0] ncount, ncompare;
    if (reset) begin
      m_sr = 0; m_epc = 0; m_count = 0; m_compare = 0;
      m_ip = 0; m_prev = 0; m_tflag = 0; m_bd = 0; m_exc = 0;
      return;
    end
    req = m_req();
    irq = m_irq();
    wr  = we && !req;
    for (int i = 0; i < 6; i++) begin
      if (EDGE[i])
        nip[i] = (hw_int[i] && !m_prev[i]) ||
                 (m_ip[i] && !(wr && addr == 5'd13 && !din[10+i]));
      else
        nip[i] = hw_int[i];
    end
    tf = m_tflag;
    if (wr && addr == 5'd11) tf = 1'b0;
    else if (m_count == m_compare && m_compare != 0) tf = 1'b1;
    ncount   = (wr && addr == 5'd9) ? din : m_count + 1;
    ncompare = (wr && addr == 5'd11) ? din : m_compare;
    if (req) begin
      m_sr[1] = 1'b1;
      m_exc   = irq ? 5'd0 : exc_code;
      m_bd    = bd;
      m_epc   = {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);
    end else begin
      if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = {din[31:2], 2'b00};
      if (exl_clr) m_sr[1] = 1'b0;
    end
    m_ip = nip; m_prev = hw_int; m_tflag = tf;
    m_count = ncount; m_compare = ncompare;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
    checks++; if (epc_out !== 32'd0) begin errors++; $display("FAIL reset_epc_out: got %h expected 0", epc_out); end
    addr = 5'd12; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_sr: got %h expected 0", dout); end
    addr = 5'd13; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_cause: got %h expected 0", dout); end
    addr = 5'd9; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", dout); end
    addr = 5'd15; #1;
    checks++; if (dout !== PRID) begin errors++; $display("FAIL prid: got %h expected %h", dout, PRID); end
    reset = 1'b0;
  endtask

  task automatic test_level_int();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; pc = 32'h3008; bd = 1'b0; #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL level_same_cycle: got %b expected 0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL level_req: got %b expected 1", int_req); end
    tick();
    addr = 5'd13; #1;
    checks++; if (dout !== 32'h0000_0400) begin errors++; $display("FAIL level_cause: got %h expected 00000400", dout); end
    checks++; if (epc_out !== 32'h3008) begin errors++; $display("FAIL level_epc: got %h expected 00003008", epc_out); end
    addr = 5'd12; #1;
    checks++; if (dout !== 32'h0000_0403) begin errors++; $display("FAIL level_sr_exl: got %h expected 00000403", dout); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL level_req_after: got %b expected 0", int_req); end
    hw_int = 6'd0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_delay_slot_eret();
    exc_code = 5'd12; bd = 1'b1; pc = 32'h3010; #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL ds_req: got %b expected 1", int_req); end
    tick();
    exc_code = 5'd0; bd = 1'b0; addr = 5'd13; #1;
    checks++; if (epc_out !== 32'h300C) begin errors++; $display("FAIL ds_epc: got %h expected 0000300c", epc_out); end
    checks++; if (dout !== 32'h8000_0030) begin errors++; $display("FAIL ds_cause: got %h expected 80000030", dout); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0; addr = 5'd12; #1;
    checks++; if (dout !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr: got %h expected 00000401", dout); end
  endtask

  task automatic test_priority();
    mtc0(5'd12, 32'h0000_0801);
    hw_int = 6'b000010;
    tick();
    hw_int = 6'd0; exc_code = 5'd10; #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b expected 1", int_req); end
    tick();
    exc_code = 5'd0; addr = 5'd13; #1;
    checks++; if (dout !== 32'h0000_0800) begin errors++; $display("FAIL prio_cause: got %h expected 00000800", dout); end
    mtc0(5'd13, 32'd0);
    addr = 5'd13; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL edge_clear: got %h expected 0", dout); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL prio_after_eret: got %b expected 0", int_req); end
  endtask

  task automatic test_timer();
    pc = 32'h3020;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (5) tick();
    addr = 5'd9; #1;
    checks++; if (int_req !== 1'b0 || dout !== 32'd5) begin errors++; $display("FAIL timer_early: got req %b count %0d expected req 0 count 5", int_req, dout); end
    tick();
    checks++; if (int_req !== 1'b1 || dout !== 32'd6) begin errors++; $display("FAIL timer_fire: got req %b count %0d expected req 1 count 6", int_req, dout); end
    tick();
    addr = 5'd13; #1;
    checks++; if (dout !== 32'h0000_8000) begin errors++; $display("FAIL timer_cause: got %h expected 00008000", dout); end
    mtc0(5'd11, 32'd100);
    addr = 5'd13; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL timer_clear: got %h expected 0", dout); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_masking();
    mtc0(5'd12, 32'h0000_0403);
    hw_int = 6'b000001; exc_code = 5'd4;
    tick(); #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_exl_req: got %b expected 0", int_req); end
    tick();
    addr = 5'd13; #1;
    checks++; if (dout !== 32'h0000_0400 || epc_out !== 32'h3020) begin errors++; $display("FAIL mask_exl_regs: got cause %h epc %h expected 00000400 00003020", dout, epc_out); end
    addr = 5'd12; #1;
    checks++; if (dout !== 32'h0000_0403) begin errors++; $display("FAIL mask_exl_sr: got %h expected 00000403", dout); end
    exc_code = 5'd0;
    mtc0(5'd12, 32'h0000_0400);
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_ie_req: got %b expected 0", int_req); end
    hw_int = 6'd0;
    tick();
  endtask

  task automatic test_reset_mid_handler();
    mtc0(5'd12, 32'h0000_0403);
    mtc0(5'd14, 32'h3008);
    checks++; if (epc_out !== 32'h3008) begin errors++; $display("FAIL mid_epc_set: got %h expected 00003008", epc_out); end
    reset = 1'b1; we = 1'b1; addr = 5'd12; din = 32'hFFFF_FFFF; hw_int = 6'h3F; exc_code = 5'd5;
    tick();
    we = 1'b0; hw_int = 6'd0; exc_code = 5'd0; addr = 5'd14; #1;
    checks++; if (dout !== 32'd0 || epc_out !== 32'd0) begin errors++; $display("FAIL mid_reset_epc: got dout %h epc %h expected 0", dout, epc_out); end
    addr = 5'd12; #1;
    checks++; if (dout !== 32'd0 || int_req !== 1'b0) begin errors++; $display("FAIL mid_reset_sr: got sr %h req %b expected 0", dout, int_req); end
    addr = 5'd13; #1;
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL mid_reset_cause: got %h expected 0", dout); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] alist [8];
    alist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd12};
    for (int n = 0; n < 2000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      hw_int   = 6'($urandom);
      we       = ($urandom_range(0, 3) == 0);
      addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : alist[$urandom_range(0, 7)];
      din      = (addr == 5'd9 || addr == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      pc       = $urandom;
      bd       = 1'($urandom);
      exc_code = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      exl_clr  = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (int_req !== m_req() || epc_out !== m_epc || dout !== m_read(addr)) begin
        errors++;
        $display("FAIL random[%0d] addr %0d: got req %b epc %h dout %h expected req %b epc %h dout %h",
                 n, addr, int_req, epc_out, dout, m_req(), m_epc, m_read(addr));
      end
      tick();
    end
    reset = 1'b0; we = 1'b0; exl_clr = 1'b0; exc_code = 5'd0;
  endtask

  initial begin
    reset = 1'b1; hw_int = 6'd0; addr = 5'd0; din = 32'd0; we = 1'b0;
    pc = 32'd0; bd = 1'b0; exc_code = 5'd0; exl_clr = 1'b0;
    test_reset();
    test_level_int();
    test_delay_slot_eret();
    test_priority();
    test_timer();
    test_masking();
    test_reset_mid_handler();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised successor to the pipeline's fixed six-line coprocessor 0.
- Holds SR (12), Cause (13), EPC (14) and PRId (15), plus optional Count (9) and Compare (11).
- Supports NUM_INT interrupt lines, each configurable as level or edge, and an optional internal timer.
- Sits beside the M stage: it takes the victim PC and exception code from M and drives int_req, which flushes the pipeline and redirects fetch to the handler.

Parameters:
- NUM_INT, 6: number of hardware interrupt lines, 1..6.
- IM_LSB, 10: bit position of IM[0] in SR and IP[0] in Cause. Requires IM_LSB+NUM_INT <= 16.
- EDGE_MASK, 0: per-line mode; bit i = 1 makes line i edge-triggered and sticky.
- HAS_TIMER, 0: 1 instantiates Count/Compare; the timer ORs into line NUM_INT-1.
- PRID, 32'h4D495053: constant value read from PRId.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- hw_int  in  NUM_INT  external interrupt lines
- addr  in  5  CP0 register index (Instr[15:11]) for mfc0/mtc0
- din  in  32  mtc0 write data
- we  in  1  mtc0 write enable
- pc  in  32  PC of the M-stage instruction
- bd  in  1  M-stage instruction is in a branch delay slot
- exc_code  in  5  M-stage exception code; 0 = none
- exl_clr  in  1  eret committing
- int_req  out  1  take exception/interrupt this cycle
- epc_out  out  32  EPC register
- dout  out  32  combinational read of the register at addr

Behaviour:
- Reset: SR, Cause, EPC, Count and Compare = 0; edge latches cleared; prev-sample register = 0. Consequently int_req = 0 and epc_out = 0.
- Register layouts:
  - SR: IM at [IM_LSB +: NUM_INT], EXL at bit 1, IE at bit 0. Other bits read 0.
  - Cause: BD at bit 31, IP at [IM_LSB +: NUM_INT], ExcCode at [6:2]. Other bits read 0.
- Pending bits, registered every cycle:
  - Level line i: IP[i] <= hw_int[i].
  - Edge line i: IP[i] set when the registered previous sample is 0 and hw_int[i] is 1. It holds until an mtc0 Cause write with din[IM_LSB+i] = 0 (write-0-to-clear). Writing 1 does not set it.
  - If a set and a clear hit the same cycle, set wins.
- Timer (HAS_TIMER = 1):
  - Count increments by 1 every cycle and wraps at 2^32.
  - When Count == Compare and Compare != 0, a sticky timer flag is set.
  - The timer flag is ORed into IP[NUM_INT-1].
  - mtc0 to Compare clears the flag; mtc0 to Count loads din.
  - With HAS_TIMER = 0, registers 9/11 read 0 and ignore writes.
- Request logic (combinational):
  - irq = |(IP & IM) & IE & ~EXL.
  - erq = (exc_code != 0) & ~EXL.
  - int_req = irq | erq.
  - irq has priority over erq.
- On int_req, at the clock edge:
  - EXL <= 1.
  - ExcCode <= 0 if irq, else exc_code.
  - BD <= bd.
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}.
  - Any mtc0 in the same cycle is discarded.
  - exl_clr in the same cycle is ignored.
- exl_clr without int_req: EXL <= 0 next edge. A pending enabled interrupt then raises int_req in that following cycle.
- mtc0 (we = 1, no int_req):
  - SR: writes IM, EXL and IE only.
  - EPC: EPC <= {din[31:2],2'b00}.
  - Cause: affects edge IP bits only.
  - PRId and unlisted indices: ignored.
- mtc0 and exl_clr together: both take effect. An SR write of EXL loses to exl_clr (EXL ends 0).
- dout: combinational from current register contents, with no same-cycle write bypass. Unlisted indices read 0.
- Reset mid-handler: all state returns to reset values at the next edge, regardless of the other inputs.

Test Plan:
- Level interrupt: SR = 32'h0000_0401, hw_int = 6'b000001, pc = 32'h3008, bd = 0 → int_req = 1 one cycle after hw_int rises. After the edge: Cause = 32'h0000_0400, EPC = 32'h3008, EXL = 1, int_req = 0.
- Delay slot plus eret: exc_code = 12, bd = 1, pc = 32'h3010 → EPC = 32'h300C, Cause = 32'h8000_0030. Assert exl_clr → EXL = 0 next cycle.
- Priority: EDGE_MASK = 6'b000010 with a 1-cycle pulse on hw_int[1] and SR = 32'h0000_0801. Pending IP[1] and exc_code = 10 in the same cycle → ExcCode = 0 (interrupt wins). The pulse stays pending until an mtc0 Cause write with din = 0, after which IP[1] = 0.
- Timer: HAS_TIMER = 1, NUM_INT = 6, Compare = 5, Count = 0, SR = 32'h0000_8001 → int_req = 1 when the flag is set. Writing Compare = 100 drops IP[5].
- Masking: EXL = 1 or IE = 0 with IP & IM != 0 and exc_code = 4 → int_req = 0, and no register changes.
- Reset mid-handler: EXL = 1, EPC = 32'h3008, reset for 1 cycle → all registers 0, and dout reads 0 at addr 14.
